grant_decoder: RTL and testbench

//   Companion to the trailing/leading-zero grant encoder. Accepts an encoded

---
 rtl/grant_decoder.sv | 152 +++++++++++++++
 tb/tb_grant_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_decoder.sv
// Decodes an encoded grant index into a registered one-hot grant, holds it until the
// owner signals done or the hold timer expires, then inserts one grant-free release cycle.
module grant_decoder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MODE        = 0,
    parameter int unsigned COUNT_WIDTH = $clog2(WIDTH),
    parameter int unsigned HOLD_MAX    = 255,
    parameter int unsigned TIMER_WIDTH = $clog2(HOLD_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [COUNT_WIDTH-1:0] in_index,
    input  logic                   in_empty,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       in_done,
    output logic [WIDTH-1:0]       o_grant,
    output logic [COUNT_WIDTH-1:0] o_index,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic                   o_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(HOLD_MAX - 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       grant_q, grant_d;
    logic [COUNT_WIDTH-1:0] index_q, index_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   err_q, err_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;

    logic xfer_c;
    logic idx_oob_c;
    logic done_hit_c;
    logic timer_exp_c;

    // Port mapping: MODE 1 mirrors the index onto the opposite end of the vector.
    function automatic logic [COUNT_WIDTH-1:0] map_index(input logic [COUNT_WIDTH-1:0] idx);
        if (MODE == 0) begin
            return idx;
        end
        return COUNT_WIDTH'(WIDTH - 1 - 32'(idx));
    endfunction

    assign o_ready     = (state_q == ST_IDLE) & ~rst;
    assign xfer_c      = in_valid & o_ready;
    assign idx_oob_c   = (32'(in_index) >= WIDTH);
    assign done_hit_c  = |(in_done & grant_q);
    assign timer_exp_c = (timer_q == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_c && !in_empty && !idx_oob_c) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done_hit_c || timer_exp_c) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Done wins over a same-cycle expiry, so timeout only flags a pure timer release.
    always_comb begin
        grant_d   = grant_q;
        index_d   = index_q;
        busy_d    = busy_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_c && !in_empty) begin
                    if (idx_oob_c) begin
                        err_d = 1'b1;
                    end else begin
                        grant_d = WIDTH'(1) << map_index(in_index);
                        index_d = in_index;
                        busy_d  = 1'b1;
                        timer_d = '0;
                    end
                end
            end
            ST_GRANT: begin
                timer_d = timer_q + TIMER_WIDTH'(1);
                if (done_hit_c || timer_exp_c) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = ~done_hit_c;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            index_q   <= '0;
            busy_q    <= 1'b0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_index   = index_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;
    assign o_err     = err_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_err_timeout_excl: assert property (@(posedge clk) disable iff (rst) !(err_q && timeout_q));

endmodule

// File: tb/tb_grant_decoder.sv
// Three decoder configurations share one random stimulus stream; each is compared per
// cycle against a cycle-count model of the grant/hold/release rules.
module tb_grant_decoder;

    localparam int NI = 3;
    localparam int P_W    [NI] = '{8, 8, 6};
    localparam int P_MODE [NI] = '{0, 1, 1};
    localparam int P_HOLD [NI] = '{4, 7, 5};

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_empty;
    logic [2:0] in_index;
    logic [7:0] in_done;

    logic [7:0] g0, g1;
    logic [5:0] g2;
    logic [2:0] ix0, ix1, ix2;
    logic [2:0] busy_v, to_v, err_v, rdy_v;

    logic [7:0] obs_grant [NI];
    logic [2:0] obs_index [NI];

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: owner port, grant cycles already completed, release-gap flag.
    bit m_busy [NI];
    bit m_gap  [NI];
    bit m_err  [NI];
    bit m_to   [NI];
    int m_port [NI];
    int m_held [NI];
    int m_idx  [NI];

    grant_decoder #(.WIDTH(8), .MODE(0), .HOLD_MAX(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .in_empty(in_empty),
        .o_ready(rdy_v[0]), .in_done(in_done), .o_grant(g0), .o_index(ix0),
        .o_busy(busy_v[0]), .o_timeout(to_v[0]), .o_err(err_v[0])
    );

    grant_decoder #(.WIDTH(8), .MODE(1), .HOLD_MAX(7)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .in_empty(in_empty),
        .o_ready(rdy_v[1]), .in_done(in_done), .o_grant(g1), .o_index(ix1),
        .o_busy(busy_v[1]), .o_timeout(to_v[1]), .o_err(err_v[1])
    );

    grant_decoder #(.WIDTH(6), .MODE(1), .HOLD_MAX(5)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .in_empty(in_empty),
        .o_ready(rdy_v[2]), .in_done(in_done[5:0]), .o_grant(g2), .o_index(ix2),
        .o_busy(busy_v[2]), .o_timeout(to_v[2]), .o_err(err_v[2])
    );

    always_comb begin
        obs_grant[0] = g0;
        obs_grant[1] = g1;
        obs_grant[2] = {2'b00, g2};
        obs_index[0] = ix0;
        obs_index[1] = ix1;
        obs_index[2] = ix2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_grant(input int k);
        if (!m_busy[k]) return 8'h00;
        return 8'(1) << m_port[k];
    endfunction

    // Advance one instance's model across a rising edge using the inputs held before it.
    task automatic model_edge(input int k);
        m_err[k] = 1'b0;
        m_to[k]  = 1'b0;
        if (rst) begin
            m_busy[k] = 1'b0;
            m_gap[k]  = 1'b0;
            m_idx[k]  = 0;
            m_port[k] = 0;
            m_held[k] = 0;
        end else if (m_gap[k]) begin
            m_gap[k] = 1'b0;
        end else if (m_busy[k]) begin
            if (in_done[m_port[k]]) begin
                m_busy[k] = 1'b0;
                m_gap[k]  = 1'b1;
            end else if (m_held[k] + 1 == P_HOLD[k]) begin
                m_busy[k] = 1'b0;
                m_gap[k]  = 1'b1;
                m_to[k]   = 1'b1;
            end else begin
                m_held[k]++;
            end
        end else if (in_valid && !in_empty) begin
            if (int'(in_index) >= P_W[k]) begin
                m_err[k] = 1'b1;
            end else begin
                m_busy[k] = 1'b1;
                m_held[k] = 0;
                m_idx[k]  = int'(in_index);
                m_port[k] = (P_MODE[k] == 1) ? P_W[k] - 1 - int'(in_index) : int'(in_index);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k);
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("u%0d grant", k), 32'(obs_grant[k]), 32'(exp_grant(k)));
            check_eq($sformatf("u%0d index", k), 32'(obs_index[k]), 32'(m_idx[k]));
            check_eq($sformatf("u%0d busy", k), 32'(busy_v[k]), 32'(m_busy[k]));
            check_eq($sformatf("u%0d timeout", k), 32'(to_v[k]), 32'(m_to[k]));
            check_eq($sformatf("u%0d err", k), 32'(err_v[k]), 32'(m_err[k]));
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic e,
                         input logic [2:0] idx, input logic [7:0] d);
        rst      = r;
        in_valid = v;
        in_empty = e;
        in_index = idx;
        in_done  = d;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("u%0d ready", k), 32'(rdy_v[k]),
                     32'(!m_busy[k] && !m_gap[k] && !rst));
        end
    endtask

    task automatic rst_cycle();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

    int n_on;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_empty = 1'b0;
        in_index = 3'd0;
        in_done  = 8'h00;
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 1'b0; m_gap[k] = 1'b0; m_err[k] = 1'b0; m_to[k] = 1'b0;
            m_port[k] = 0; m_held[k] = 0; m_idx[k] = 0;
        end
        step();
        step();
        check_eq("reset u0 grant", 32'(g0), 32'h0);
        check_eq("reset u0 ready", 32'(rdy_v[0]), 32'h0);

        // Index 3 decodes differently per configuration.
        drive(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        step();
        check_eq("t1 u0 grant", 32'(g0), 32'h08);
        check_eq("t1 u1 grant", 32'(g1), 32'h10);
        check_eq("t1 u2 grant", 32'(g2), 32'h04);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        check_eq("t1 u0 ready", 32'(rdy_v[0]), 32'h0);
        check_eq("t1 u0 busy", 32'(busy_v[0]), 32'h1);
        step();

        // Mirrored index 0 then done on bit 7.
        rst_cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("t2 u1 grant", 32'(g1), 32'h80);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h80);
        step();
        check_eq("t2 u1 released", 32'(g1), 32'h00);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        check_eq("t2 u1 gap ready", 32'(rdy_v[1]), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        check_eq("t2 u1 idle ready", 32'(rdy_v[1]), 32'h1);

        // Empty transfer is consumed without a grant.
        rst_cycle();
        drive(1'b0, 1'b1, 1'b1, 3'd2, 8'h00);
        step();
        check_eq("t3 u0 grant", 32'(g0), 32'h0);
        check_eq("t3 u0 err", 32'(err_v[0]), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        check_eq("t3 u0 ready", 32'(rdy_v[0]), 32'h1);

        // Hold timer on u0 (HOLD_MAX=4): timeout, then done on the last cycle.
        rst_cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("t4 held grant", 32'(g0), 32'h04);
        end
        step();
        check_eq("t4 expired grant", 32'(g0), 32'h00);
        check_eq("t4 timeout", 32'(to_v[0]), 32'h1);
        step();
        check_eq("t4 timeout pulse", 32'(to_v[0]), 32'h0);
        rst_cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int c = 0; c < 3; c++) step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h04);
        step();
        check_eq("t4 done grant", 32'(g0), 32'h00);
        check_eq("t4 done no timeout", 32'(to_v[0]), 32'h0);

        // Out-of-range index on the 6-wide decoder, then foreign done bits.
        rst_cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
        step();
        check_eq("t5 u2 err", 32'(err_v[2]), 32'h1);
        check_eq("t5 u2 grant", 32'(g2), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("t5 u2 err pulse", 32'(err_v[2]), 32'h0);
        check_eq("t5 u2 port5", 32'(g2), 32'h20);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h01);
        step();
        check_eq("t5 u2 held", 32'(g2), 32'h20);

        // Reset during a grant, then back-to-back owners with immediate done.
        rst_cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd4, 8'h00);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("t6 rst grant", 32'(g0), 32'h0);
        check_eq("t6 rst busy", 32'(busy_v[0]), 32'h0);
        check_eq("t6 rst timeout", 32'(to_v[0]), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'd1, 8'hFF);
        n_on = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (g0 != 8'h00) n_on++;
        end
        check_eq("t6 b2b grant cycles", 32'(n_on), 32'd3);

        rst_cycle();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 3'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
